// File: rtl/midi_pkg.sv
// MIDI shared definitions: status constants, message bundle, data-length lookup.
// Used by both the MIDI transmitter and receiver.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF    = 4'h8;
  localparam logic [3:0] NOTE_ON     = 4'h9;
  localparam logic [3:0] POLY_PRESS  = 4'hA;
  localparam logic [3:0] CTRL_CHANGE = 4'hB;
  localparam logic [3:0] PROG_CHANGE = 4'hC;
  localparam logic [3:0] CHAN_PRESS  = 4'hD;
  localparam logic [3:0] PITCH_BEND  = 4'hE;

  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] MTC_QFRAME   = 8'hF1;
  localparam logic [7:0] SONG_POS     = 8'hF2;
  localparam logic [7:0] SONG_SEL     = 8'hF3;
  localparam logic [7:0] TUNE_REQ     = 8'hF6;
  localparam logic [7:0] SYSEX_END    = 8'hF7;
  localparam logic [7:0] RT_CLOCK     = 8'hF8;
  localparam logic [7:0] RT_START     = 8'hFA;
  localparam logic [7:0] RT_CONTINUE  = 8'hFB;
  localparam logic [7:0] RT_STOP      = 8'hFC;
  localparam logic [7:0] RT_SENSE     = 8'hFE;
  localparam logic [7:0] RT_RESET     = 8'hFF;

  typedef struct packed {
    logic [7:0] status;
    logic [6:0] data1;
    logic [6:0] data2;
    logic [1:0] len;
  } midi_msg_t;

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } uart_state_t;

  typedef enum logic [1:0] {
    P_NONE, P_CHAN, P_SYSCOM, P_SYSEX
  } parse_state_t;

  function automatic logic [1:0] midi_data_len(
    input logic [7:0] status
  );
    case (status[7:4])
      NOTE_OFF, NOTE_ON, POLY_PRESS,
      CTRL_CHANGE, PITCH_BEND: return 2'd2;
      PROG_CHANGE, CHAN_PRESS: return 2'd1;
      4'hF: begin
        case (status)
          MTC_QFRAME, SONG_SEL: return 2'd1;
          SONG_POS:             return 2'd2;
          default:              return 2'd0;
        endcase
      end
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/midi_rx_if.sv
// Valid/ready message port between the MIDI receiver and control logic.
// The master owns the message fields; the slave owns ready.
interface midi_rx_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;
  logic [1:0] msg_len;

  modport master (
    output msg_valid, msg_status,
    output msg_data1, msg_data2, msg_len,
    input  msg_ready
  );

  modport slave (
    input  msg_valid, msg_status,
    input  msg_data1, msg_data2, msg_len,
    output msg_ready
  );
endinterface

// File: rtl/midi_uart_rx.sv
// MIDI serial deserialiser: pin synchroniser and 8N1 bit-timing FSM.
// Emits one-cycle byte_valid or framing_err pulses after each stop sample.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int BIT_TICKS   = 3200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_in,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int TW = $clog2(BIT_TICKS);
  localparam logic [TW-1:0] TICK_MAX =
    TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] HALF_MAX =
    TW'(BIT_TICKS / 2 - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   line;
  uart_state_t            state;
  logic [TW-1:0]          tick;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;

  assign line = sync[SYNC_STAGES-1];
  assign data = shreg;

  // Bring the asynchronous pin into the clk domain; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '1;
    else      sync <= {sync[SYNC_STAGES-2:0], midi_in};
  end

  // Start detect, mid-bit sampling and stop-bit check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      tick        <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          tick <= '0;
          if (!line) state <= S_START;
        end
        S_START: begin
          if (tick == HALF_MAX) begin
            tick   <= '0;
            bitcnt <= '0;
            state  <= line ? S_IDLE : S_DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        S_DATA: begin
          if (tick == TICK_MAX) begin
            tick   <= '0;
            shreg  <= {line, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= S_STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        S_STOP: begin
          if (tick == TICK_MAX) begin
            tick        <= '0;
            byte_valid  <= line;
            framing_err <= !line;
            state       <= S_IDLE;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/midi_rx.sv
// MIDI IN receiver: message parser with running status and a
// single-entry holding register on a valid/ready port.
module midi_rx
  import midi_pkg::*;
#(
  parameter int BIT_TICKS   = 3200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_in,
  midi_rx_if.master  msg,
  output logic       framing_err,
  output logic       overrun
);

  logic [7:0]   rx_byte;
  logic         byte_valid;
  parse_state_t pst, pst_n;
  logic [7:0]   status, status_n;
  logic [1:0]   expect_len, expect_n;
  logic [1:0]   idx, idx_n;
  logic [6:0]   d1, d1_n;
  logic         emit;
  midi_msg_t    emit_msg;
  midi_msg_t    hold;
  logic         hold_valid;
  logic         is_rt, is_chan, is_sys, is_data;

  midi_uart_rx #(
    .BIT_TICKS   (BIT_TICKS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_uart (
    .clk         (clk),
    .rst         (rst),
    .midi_in     (midi_in),
    .data        (rx_byte),
    .byte_valid  (byte_valid),
    .framing_err (framing_err)
  );

  assign is_rt   = rx_byte >= RT_CLOCK;
  assign is_chan = rx_byte[7] && rx_byte[7:4] != 4'hF;
  assign is_sys  = rx_byte[7:4] == 4'hF && !is_rt;
  assign is_data = !rx_byte[7];

  // Decode each received byte into next parser state and an emit request.
  always_comb begin
    pst_n    = pst;
    status_n = status;
    expect_n = expect_len;
    idx_n    = idx;
    d1_n     = d1;
    emit     = 1'b0;
    emit_msg = '0;
    if (framing_err) begin
      idx_n = '0;
    end else if (byte_valid) begin
      unique case (1'b1)
        is_rt: begin
          emit            = 1'b1;
          emit_msg.status = rx_byte;
        end
        is_chan: begin
          pst_n    = P_CHAN;
          status_n = rx_byte;
          expect_n = midi_data_len(rx_byte);
          idx_n    = '0;
        end
        is_sys: begin
          idx_n = '0;
          if (rx_byte == SYSEX_START) begin
            pst_n = P_SYSEX;
          end else if (rx_byte == TUNE_REQ) begin
            pst_n           = P_NONE;
            emit            = 1'b1;
            emit_msg.status = rx_byte;
          end else if (midi_data_len(rx_byte) != 2'd0) begin
            pst_n    = P_SYSCOM;
            status_n = rx_byte;
            expect_n = midi_data_len(rx_byte);
          end else begin
            pst_n = P_NONE;
          end
        end
        is_data: begin
          if (pst == P_CHAN || pst == P_SYSCOM) begin
            if (idx + 2'd1 == expect_len) begin
              emit            = 1'b1;
              emit_msg.status = status;
              emit_msg.len    = expect_len;
              emit_msg.data1  = (idx == 2'd0) ? rx_byte[6:0] : d1;
              emit_msg.data2  = (idx == 2'd0) ? 7'd0 : rx_byte[6:0];
              idx_n           = '0;
              if (pst == P_SYSCOM) pst_n = P_NONE;
            end else begin
              d1_n  = rx_byte[6:0];
              idx_n = idx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Parser registers, holding register and overrun pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pst        <= P_NONE;
      status     <= '0;
      expect_len <= '0;
      idx        <= '0;
      d1         <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pst        <= pst_n;
      status     <= status_n;
      expect_len <= expect_n;
      idx        <= idx_n;
      d1         <= d1_n;
      overrun    <= 1'b0;
      if (emit) begin
        if (!hold_valid || msg.msg_ready) begin
          hold       <= emit_msg;
          hold_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (hold_valid && msg.msg_ready) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign msg.msg_valid  = hold_valid;
  assign msg.msg_status = hold.status;
  assign msg.msg_data1  = hold.data1;
  assign msg.msg_data2  = hold.data2;
  assign msg.msg_len    = hold.len;

endmodule

// File: tb/tb_midi_rx.sv
// Directed bench for midi_rx at 16 clk per bit.
// Messages are captured on transfer and compared to hand-built tuples.
module tb_midi_rx;

  localparam int BT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic midi_in = 1'b1;
  logic framing_err;
  logic overrun;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [23:0] q[$];

  midi_rx_if bus();

  midi_rx #(
    .BIT_TICKS   (BT),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .midi_in     (midi_in),
    .msg         (bus),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] m(
    input logic [7:0] s, input logic [6:0] a,
    input logic [6:0] b, input logic [1:0] l);
    return {s, a, b, l};
  endfunction

  function automatic logic [23:0] outs();
    return {bus.msg_status, bus.msg_data1,
            bus.msg_data2, bus.msg_len};
  endfunction

  // Capture transfers and error pulses between clock edges.
  always @(negedge clk) begin
    if (bus.msg_valid && bus.msg_ready) q.push_back(outs());
    if (framing_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic send_bit(input logic b);
    midi_in = b;
    repeat (BT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    midi_in = 1'b1;
    bus.msg_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.msg_valid, framing_err, overrun} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got %b want 000",
               {bus.msg_valid, framing_err, overrun});
    end
    total++;
    if (outs() !== 24'h0) begin
      bad++;
      $display("FAIL reset_fields got %h want 000000", outs());
    end
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (bus.msg_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_valid got %b want 0", bus.msg_valid);
    end
  endtask

  task automatic test_note_on();
    int base;
    logic [7:0] b;
    base = q.size();
    b = 8'h64;
    send_frame(8'h90, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    midi_in = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    total++;
    if (bus.msg_valid !== 1'b0) begin
      bad++;
      $display("FAIL lat_early got %b want 0", bus.msg_valid);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.msg_valid !== 1'b1) begin
      bad++;
      $display("FAIL lat_on got %b want 1", bus.msg_valid);
    end
    total++;
    if (outs() !== m(8'h90, 7'h3C, 7'h64, 2'd2)) begin
      bad++;
      $display("FAIL note_fields got %h want %h",
               outs(), m(8'h90, 7'h3C, 7'h64, 2'd2));
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.msg_valid !== 1'b0) begin
      bad++;
      $display("FAIL note_drop got %b want 0", bus.msg_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q.size() - base !== 1) begin
      bad++;
      $display("FAIL note_count got %0d want 1", q.size() - base);
    end
  endtask

  task automatic test_running();
    int base;
    base = q.size();
    send_frame(8'h90, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h64, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h00, 1'b1);
    idle(1);
    total++;
    if (q.size() - base !== 2) begin
      bad++;
      $display("FAIL run_count got %0d want 2", q.size() - base);
    end else begin
      total++;
      if (q[base] !== m(8'h90, 7'h3C, 7'h64, 2'd2)) begin
        bad++;
        $display("FAIL run_msg0 got %h want %h",
                 q[base], m(8'h90, 7'h3C, 7'h64, 2'd2));
      end
      total++;
      if (q[base+1] !== m(8'h90, 7'h3C, 7'h00, 2'd2)) begin
        bad++;
        $display("FAIL run_msg1 got %h want %h",
                 q[base+1], m(8'h90, 7'h3C, 7'h00, 2'd2));
      end
    end
  endtask

  task automatic test_program();
    int base;
    base = q.size();
    send_frame(8'hC5, 1'b1);
    send_frame(8'h07, 1'b1);
    idle(1);
    total++;
    if (q.size() - base !== 1) begin
      bad++;
      $display("FAIL pc_count got %0d want 1", q.size() - base);
    end else begin
      total++;
      if (q[base] !== m(8'hC5, 7'h07, 7'h00, 2'd1)) begin
        bad++;
        $display("FAIL pc_msg got %h want %h",
                 q[base], m(8'hC5, 7'h07, 7'h00, 2'd1));
      end
    end
  endtask

  task automatic test_realtime();
    int base;
    base = q.size();
    send_frame(8'h90, 1'b1);
    send_frame(8'hF8, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h64, 1'b1);
    idle(1);
    total++;
    if (q.size() - base !== 2) begin
      bad++;
      $display("FAIL rt_count got %0d want 2", q.size() - base);
    end else begin
      total++;
      if (q[base] !== m(8'hF8, 7'h00, 7'h00, 2'd0)) begin
        bad++;
        $display("FAIL rt_msg0 got %h want %h",
                 q[base], m(8'hF8, 7'h00, 7'h00, 2'd0));
      end
      total++;
      if (q[base+1] !== m(8'h90, 7'h3C, 7'h64, 2'd2)) begin
        bad++;
        $display("FAIL rt_msg1 got %h want %h",
                 q[base+1], m(8'h90, 7'h3C, 7'h64, 2'd2));
      end
    end
  endtask

  task automatic test_framing();
    int base;
    int fe0;
    send_frame(8'hF4, 1'b1);
    base = q.size();
    fe0 = fe_cnt;
    send_frame(8'h90, 1'b0);
    idle(1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h64, 1'b1);
    idle(1);
    total++;
    if (fe_cnt - fe0 !== 1) begin
      bad++;
      $display("FAIL fe_pulses got %0d want 1", fe_cnt - fe0);
    end
    total++;
    if (q.size() - base !== 0) begin
      bad++;
      $display("FAIL fe_nomsg got %0d want 0", q.size() - base);
    end
    send_frame(8'h80, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h00, 1'b1);
    idle(1);
    total++;
    if (q.size() - base !== 1) begin
      bad++;
      $display("FAIL fe_recover got %0d want 1", q.size() - base);
    end else begin
      total++;
      if (q[base] !== m(8'h80, 7'h3C, 7'h00, 2'd2)) begin
        bad++;
        $display("FAIL fe_recover_msg got %h want %h",
                 q[base], m(8'h80, 7'h3C, 7'h00, 2'd2));
      end
    end
  endtask

  task automatic test_overrun();
    int base;
    int ov0;
    base = q.size();
    ov0 = ov_cnt;
    bus.msg_ready = 1'b0;
    send_frame(8'h90, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h64, 1'b1);
    idle(1);
    total++;
    if (bus.msg_valid !== 1'b1) begin
      bad++;
      $display("FAIL ov_held got %b want 1", bus.msg_valid);
    end
    send_frame(8'h80, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h00, 1'b1);
    idle(1);
    total++;
    if (ov_cnt - ov0 !== 1) begin
      bad++;
      $display("FAIL ov_pulses got %0d want 1", ov_cnt - ov0);
    end
    total++;
    if (outs() !== m(8'h90, 7'h3C, 7'h64, 2'd2)) begin
      bad++;
      $display("FAIL ov_stable got %h want %h",
               outs(), m(8'h90, 7'h3C, 7'h64, 2'd2));
    end
    bus.msg_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.msg_valid !== 1'b0) begin
      bad++;
      $display("FAIL ov_drain got %b want 0", bus.msg_valid);
    end
    total++;
    if (q.size() - base !== 1) begin
      bad++;
      $display("FAIL ov_count got %0d want 1", q.size() - base);
    end else begin
      total++;
      if (q[base] !== m(8'h90, 7'h3C, 7'h64, 2'd2)) begin
        bad++;
        $display("FAIL ov_msg got %h want %h",
                 q[base], m(8'h90, 7'h3C, 7'h64, 2'd2));
      end
    end
  endtask

  task automatic test_glitch();
    int base;
    int fe0;
    base = q.size();
    fe0 = fe_cnt;
    midi_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(12);
    total++;
    if (q.size() - base !== 0 || fe_cnt - fe0 !== 0) begin
      bad++;
      $display("FAIL glitch got msgs=%0d fe=%0d want 0 0",
               q.size() - base, fe_cnt - fe0);
    end
    send_frame(8'h90, 1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(1);
    total++;
    if (q.size() - base !== 1) begin
      bad++;
      $display("FAIL glitch_after got %0d want 1", q.size() - base);
    end else begin
      total++;
      if (q[base] !== m(8'h90, 7'h11, 7'h22, 2'd2)) begin
        bad++;
        $display("FAIL glitch_msg got %h want %h",
                 q[base], m(8'h90, 7'h11, 7'h22, 2'd2));
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bus.msg_ready = 1'b0;
    send_frame(8'h90, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h64, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    midi_in = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if ({bus.msg_valid, framing_err, overrun} !== 3'b000 ||
        outs() !== 24'h0) begin
      bad++;
      $display("FAIL rst_mid got v=%b fe=%b ov=%b f=%h want 0",
               bus.msg_valid, framing_err, overrun, outs());
    end
    midi_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.msg_ready = 1'b1;
    base = q.size();
    idle(2);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h64, 1'b1);
    idle(1);
    total++;
    if (q.size() - base !== 0) begin
      bad++;
      $display("FAIL rst_status_cleared got %0d want 0",
               q.size() - base);
    end
    send_frame(8'h90, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h64, 1'b1);
    idle(1);
    total++;
    if (q.size() - base !== 1) begin
      bad++;
      $display("FAIL rst_next got %0d want 1", q.size() - base);
    end else begin
      total++;
      if (q[base] !== m(8'h90, 7'h3C, 7'h64, 2'd2)) begin
        bad++;
        $display("FAIL rst_next_msg got %h want %h",
                 q[base], m(8'h90, 7'h3C, 7'h64, 2'd2));
      end
    end
  endtask

  task automatic test_sysex();
    int base;
    base = q.size();
    send_frame(8'hF0, 1'b1);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'hF7, 1'b1);
    send_frame(8'h90, 1'b1);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h64, 1'b1);
    idle(1);
    total++;
    if (q.size() - base !== 1) begin
      bad++;
      $display("FAIL sysex_count got %0d want 1", q.size() - base);
    end else begin
      total++;
      if (q[base] !== m(8'h90, 7'h3C, 7'h64, 2'd2)) begin
        bad++;
        $display("FAIL sysex_msg got %h want %h",
                 q[base], m(8'h90, 7'h3C, 7'h64, 2'd2));
      end
    end
  endtask

  initial begin
    bus.msg_ready = 1'b1;
    test_reset();
    test_note_on();
    test_running();
    test_program();
    test_realtime();
    test_framing();
    test_overrun();
    test_glitch();
    test_reset_mid();
    test_sysex();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
